// File: rtl/micro_seq_pkg.sv
`default_nettype none
// ============================================================================
// micro_seq_pkg
//   Microword field positions, sequencer state encoding and opcode entry mapping.
//   Revision: 1.0
// ============================================================================
package micro_seq_pkg;

  localparam int UEND_BIT      = 43;
  localparam int UJMP_BIT      = 42;
  localparam int UTGT_HI       = 41;
  localparam int UTGT_LO       = 32;
  localparam int CTRL_HI       = 31;
  localparam int CTRL_LO       = 0;
  localparam int PKG_OP_W      = 8;
  localparam int PKG_SLOT_BITS = 2;
  localparam int PKG_UADDR_W   = PKG_OP_W + PKG_SLOT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } useq_state_e;

  function automatic logic [PKG_UADDR_W-1:0] entry_addr(input logic [PKG_OP_W-1:0] op);
    return {op, {PKG_SLOT_BITS{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/useq_watchdog.sv
`default_nettype none
// ============================================================================
// useq_watchdog
//   Counts microinstructions of the current opcode; flags when the limit is hit.
//   Revision: 1.0
// ============================================================================
module useq_watchdog #(
  parameter int MAX_USTEPS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam int CNT_W = $clog2(MAX_USTEPS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear loads 1: the entry word itself is the first microinstruction.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == CNT_W'(MAX_USTEPS));

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// micro_sequencer
//   Walks an opcode's microcode in a registered-address ROM and forwards control bits.
//   Revision: 1.0
// ============================================================================
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int OP_W       = 8,
  parameter int UADDR_W    = 10,
  parameter int UWORD_W    = 44,
  parameter int CTRL_W     = 32,
  parameter int SLOT_BITS  = 2,
  parameter int MAX_USTEPS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  output logic               instr_ready_o,
  input  logic               cond_i,
  input  logic               stall_i,
  output logic [UADDR_W-1:0] rom_addr_o,
  input  logic [UWORD_W-1:0] rom_v_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               ctrl_valid_o,
  output logic               fault_o
);

  localparam logic [UADDR_W-1:0] UPC_MAX = '1;

  useq_state_e        state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               fault_q, fault_d;

  logic [UADDR_W-1:0] w_entry;
  logic [UADDR_W-1:0] w_addr;
  logic               w_ready;
  logic               w_ctrl_valid;
  logic [CTRL_W-1:0]  w_ctrl;
  logic               w_accept;
  logic               w_take;
  logic               w_wd_clr;
  logic               w_wd_inc;
  logic               w_wd_limit;

  generate
    if (OP_W == PKG_OP_W && SLOT_BITS == PKG_SLOT_BITS && UADDR_W == PKG_UADDR_W) begin : g_pkg_entry
      assign w_entry = entry_addr(instr_op_i);
    end else begin : g_gen_entry
      assign w_entry = {instr_op_i, {SLOT_BITS{1'b0}}};
    end
  endgenerate

  // No opcode may be taken while reset is held, so the ROM address stays at 0.
  assign w_accept = instr_valid_i & rst_n;
  assign w_take   = rom_v_i[UJMP_BIT] & cond_i;

  useq_watchdog #(
    .MAX_USTEPS(MAX_USTEPS)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_wd_clr),
    .inc_i  (w_wd_inc),
    .limit_o(w_wd_limit)
  );

  always_comb begin
    state_d      = state_q;
    upc_d        = upc_q;
    fault_d      = fault_q;
    w_addr       = upc_q;
    w_ready      = 1'b0;
    w_ctrl_valid = 1'b0;
    w_ctrl       = '0;
    w_wd_clr     = 1'b0;
    w_wd_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_addr   = w_entry;
          upc_d    = w_entry;
          w_wd_clr = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ctrl       = rom_v_i[CTRL_HI:CTRL_LO];
        w_ctrl_valid = !stall_i;
        if (!stall_i) begin
          if (rom_v_i[UEND_BIT]) begin
            w_ready = 1'b1;
            if (w_accept) begin
              w_addr   = w_entry;
              upc_d    = w_entry;
              w_wd_clr = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (w_wd_limit || (!w_take && upc_q == UPC_MAX)) begin
            // Runaway or falling off the top of the ROM: freeze until reset.
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            w_addr   = w_take ? rom_v_i[UTGT_HI:UTGT_LO] : upc_q + UADDR_W'(1);
            upc_d    = w_addr;
            w_wd_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      fault_q <= fault_d;
    end
  end

  assign rom_addr_o    = w_addr;
  assign instr_ready_o = w_ready & rst_n;
  assign ctrl_o        = w_ctrl;
  assign ctrl_valid_o  = w_ctrl_valid;
  assign fault_o       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// tb_micro_sequencer
//   Directed scenarios plus randomized opcode traffic against a trace-level model.
// ============================================================================
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [7:0]  instr_op = 8'h00;
  logic        cond = 1'b0;
  logic        stall = 1'b0;
  logic        instr_ready;
  logic [9:0]  rom_addr;
  logic [43:0] rom_v;
  logic [31:0] ctrl;
  logic        ctrl_valid;
  logic        fault;

  logic [43:0] mem [0:1023];
  logic [9:0]  rom_areg = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_areg <= rom_addr;
  assign rom_v = mem[rom_areg];

  micro_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid_i(instr_valid),
    .instr_op_i   (instr_op),
    .instr_ready_o(instr_ready),
    .cond_i       (cond),
    .stall_i      (stall),
    .rom_addr_o   (rom_addr),
    .rom_v_i      (rom_v),
    .ctrl_o       (ctrl),
    .ctrl_valid_o (ctrl_valid),
    .fault_o      (fault)
  );

  function automatic logic [43:0] uw(input bit e, input bit j, input logic [9:0] t,
                                     input logic [31:0] c);
    return {e, j, t, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic c, input logic s);
    @(negedge clk);
    instr_valid = v;
    instr_op    = op;
    cond        = c;
    stall       = s;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] a, input logic rdy,
                            input logic cv, input logic [31:0] ct, input logic f);
    chk({tag, ".rom_addr"},    64'(rom_addr),    64'(a));
    chk({tag, ".instr_ready"}, 64'(instr_ready), 64'(rdy));
    chk({tag, ".ctrl_valid"},  64'(ctrl_valid),  64'(cv));
    chk({tag, ".ctrl"},        64'(ctrl),        64'(ct));
    chk({tag, ".fault"},       64'(fault),       64'(f));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    expect_out("rst", 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic        m_busy, nb, v, c, s, e_rdy, e_cv;
    logic [9:0]  m_pc, e_a, base;
    logic [7:0]  op;
    logic [31:0] e_ct;
    logic [43:0] w;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h014] = uw(0, 0, 10'h0, 32'h1111_0014);
    mem[10'h015] = uw(0, 0, 10'h0, 32'h1111_0015);
    mem[10'h016] = uw(1, 0, 10'h0, 32'h1111_0016);
    mem[10'h018] = uw(1, 0, 10'h0, 32'h2222_0018);
    mem[10'h020] = uw(0, 1, 10'h3F0, 32'h3333_0020);
    mem[10'h021] = uw(1, 0, 10'h0, 32'h3333_0021);
    mem[10'h3F0] = uw(1, 0, 10'h0, 32'h3333_03F0);
    mem[10'h024] = uw(1, 1, 10'h3F0, 32'h3333_0024);
    mem[10'h028] = uw(0, 0, 10'h0, 32'h4444_0028);
    mem[10'h029] = uw(0, 0, 10'h0, 32'h4444_0029);
    mem[10'h02A] = uw(1, 0, 10'h0, 32'h4444_002A);
    for (int i = 0; i < 16; i++) mem[10'h040 + i] = uw(0, 0, 10'h0, 32'h5555_0040 + i);
    for (int i = 0; i < 4; i++) mem[10'h3FC + i] = uw(0, 0, 10'h0, 32'h6666_03FC + i);

    // Reset state
    @(negedge clk);
    #1;
    expect_out("reset", 10'h000, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line opcode 0x05
    drive(1, 8'h05, 0, 0); expect_out("t1.accept", 10'h014, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t1.w0", 10'h015, 0, 1, 32'h1111_0014, 0);
    drive(0, 8'h00, 0, 0); expect_out("t1.w1", 10'h016, 0, 1, 32'h1111_0015, 0);
    drive(0, 8'h00, 0, 0); expect_out("t1.end", 10'h016, 1, 1, 32'h1111_0016, 0);
    drive(0, 8'h00, 0, 0); expect_out("t1.idle", 10'h016, 1, 0, 32'h0, 0);

    // Back-to-back opcodes
    drive(1, 8'h05, 0, 0); expect_out("t2.accept", 10'h014, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t2.w0", 10'h015, 0, 1, 32'h1111_0014, 0);
    drive(0, 8'h00, 0, 0); expect_out("t2.w1", 10'h016, 0, 1, 32'h1111_0015, 0);
    drive(1, 8'h06, 0, 0); expect_out("t2.b2b", 10'h018, 1, 1, 32'h1111_0016, 0);
    drive(0, 8'h00, 0, 0); expect_out("t2.op6", 10'h018, 1, 1, 32'h2222_0018, 0);
    drive(0, 8'h00, 0, 0); expect_out("t2.idle", 10'h018, 1, 0, 32'h0, 0);

    // Conditional jump taken / not taken, and end overriding jump
    drive(1, 8'h08, 0, 0); expect_out("t3.acc1", 10'h020, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 1, 0); expect_out("t3.jmp", 10'h3F0, 0, 1, 32'h3333_0020, 0);
    drive(0, 8'h00, 0, 0); expect_out("t3.tgt", 10'h3F0, 1, 1, 32'h3333_03F0, 0);
    drive(1, 8'h08, 0, 0); expect_out("t3.acc2", 10'h020, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t3.nojmp", 10'h021, 0, 1, 32'h3333_0020, 0);
    drive(0, 8'h00, 0, 0); expect_out("t3.fall", 10'h021, 1, 1, 32'h3333_0021, 0);
    drive(1, 8'h09, 1, 0); expect_out("t3.acc3", 10'h024, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 1, 0); expect_out("t3.endwins", 10'h024, 1, 1, 32'h3333_0024, 0);
    drive(0, 8'h00, 1, 0); expect_out("t3.idle", 10'h024, 1, 0, 32'h0, 0);

    // Stall for 3 cycles mid-opcode
    drive(1, 8'h0A, 0, 0); expect_out("t4.accept", 10'h028, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t4.w0", 10'h029, 0, 1, 32'h4444_0028, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h05, 1, 1); expect_out("t4.stall", 10'h029, 0, 0, 32'h4444_0029, 0);
    end
    drive(0, 8'h00, 0, 0); expect_out("t4.resume", 10'h02A, 0, 1, 32'h4444_0029, 0);
    drive(0, 8'h00, 0, 0); expect_out("t4.end", 10'h02A, 1, 1, 32'h4444_002A, 0);
    drive(0, 8'h00, 0, 1); expect_out("t4.idle", 10'h02A, 1, 0, 32'h0, 0);

    // Watchdog: 16 words without an end marker
    drive(1, 8'h10, 0, 0); expect_out("t5.accept", 10'h040, 1, 0, 32'h0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 8'h00, 0, 0);
      expect_out("t5.walk", 10'h041 + 10'(i), 0, 1, 32'h5555_0040 + i, 0);
    end
    drive(0, 8'h00, 0, 0);
    chk("t5.w15.ctrl_valid", 64'(ctrl_valid), 64'(1'b1));
    chk("t5.w15.ctrl", 64'(ctrl), 64'h5555_004F);
    drive(1, 8'h05, 0, 0); expect_out("t5.halt", 10'h04F, 0, 0, 32'h0, 1);
    drive(1, 8'h05, 1, 1); expect_out("t5.halt2", 10'h04F, 0, 0, 32'h0, 1);
    pulse_reset();

    // Top of ROM without an end marker must fault instead of wrapping
    drive(1, 8'hFF, 0, 0); expect_out("t5b.accept", 10'h3FC, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t5b.w0", 10'h3FD, 0, 1, 32'h6666_03FC, 0);
    drive(0, 8'h00, 0, 0); expect_out("t5b.w1", 10'h3FE, 0, 1, 32'h6666_03FD, 0);
    drive(0, 8'h00, 0, 0); expect_out("t5b.w2", 10'h3FF, 0, 1, 32'h6666_03FE, 0);
    drive(0, 8'h00, 0, 0);
    chk("t5b.nowrap", 64'(rom_addr == 10'h000), 64'(1'b0));
    chk("t5b.w3.ctrl", 64'(ctrl), 64'h6666_03FF);
    drive(0, 8'h00, 0, 0); expect_out("t5b.halt", 10'h3FF, 0, 0, 32'h0, 1);
    pulse_reset();

    // Reset asserted mid-RUN
    drive(1, 8'h05, 0, 0); expect_out("t6.accept", 10'h014, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t6.w0", 10'h015, 0, 1, 32'h1111_0014, 0);
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b1;
    #1;
    expect_out("t6.rst", 10'h000, 0, 0, 32'h0, 0);
    drive(1, 8'h06, 0, 0); expect_out("t6.rsthold", 10'h000, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_out("t6.accept2", 10'h018, 1, 0, 32'h0, 0);
    drive(0, 8'h00, 0, 0); expect_out("t6.op6", 10'h018, 1, 1, 32'h2222_0018, 0);
    drive(0, 8'h00, 0, 0); expect_out("t6.idle", 10'h018, 1, 0, 32'h0, 0);

    // Randomized traffic over short programs at opcodes 0x80..0x8F
    for (int k = 0; k < 16; k++) begin
      base = {8'h80 | 8'(k), 2'b00};
      mem[base]     = uw(0, 1'($urandom % 2), base + 10'd3, $urandom);
      mem[base + 1] = uw(1'($urandom % 2), 0, 10'h0, $urandom);
      mem[base + 2] = uw(1, 0, 10'h0, $urandom);
      mem[base + 3] = uw(1, 1'($urandom % 2), 10'h3F0, $urandom);
    end
    pulse_reset();
    m_busy = 1'b0;
    m_pc   = 10'h000;
    for (int n = 0; n < 400; n++) begin
      v  = 1'($urandom % 2);
      op = 8'h80 | 8'($urandom % 16);
      c  = 1'($urandom % 2);
      s  = ($urandom % 4) == 0;
      drive(v, op, c, s);
      if (!m_busy) begin
        e_rdy = 1'b1; e_cv = 1'b0; e_ct = 32'h0;
        e_a = v ? {op, 2'b00} : m_pc;
        nb  = v;
      end else begin
        w = mem[m_pc];
        e_ct = w[31:0];
        e_cv = !s;
        if (s) begin
          e_rdy = 1'b0; e_a = m_pc; nb = 1'b1;
        end else if (w[43]) begin
          e_rdy = 1'b1; e_a = v ? {op, 2'b00} : m_pc; nb = v;
        end else begin
          e_rdy = 1'b0; e_a = (w[42] && c) ? w[41:32] : m_pc + 10'd1; nb = 1'b1;
        end
      end
      expect_out("rand", e_a, e_rdy, e_cv, e_ct, 1'b0);
      m_pc   = e_a;
      m_busy = nb;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
